// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial add/subtract sequencer built around one shared 4-bit ripple slice.
// Ports: clk, rst (sync, active-high); req_valid/req_ready + a, b, cin, sub in;
// res_valid/res_ready + sum, cout, ovf out; busy high while an operation is owned.

module fourbitadder (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);
   logic c;

   always_comb begin
      c = cin;
      sum = '0;
      for (int i = 0; i < 4; i++) begin
         sum[i] = a[i] ^ b[i] ^ c;
         c = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      cout = c;
   end
endmodule

module nibble_serial_add_ctrl #(
   parameter int NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [4*NIBBLES-1:0] a,
   input  logic [4*NIBBLES-1:0] b,
   input  logic                 cin,
   input  logic                 sub,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [4*NIBBLES-1:0] sum,
   output logic                 cout,
   output logic                 ovf,
   output logic                 busy
);
   localparam int W  = 4 * NIBBLES;
   localparam int IW = $clog2(NIBBLES);
   localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [W-1:0]  a_q, a_d;
   logic [W-1:0]  b_q, b_d;
   logic [W-1:0]  sum_q, sum_d;
   logic          carry_q, carry_d;
   logic          cout_q, cout_d;
   logic          ovf_q, ovf_d;

   logic [3:0]    sl_a, sl_b, sl_sum;
   logic          sl_co;

   fourbitadder u_slice (
      .a    (sl_a),
      .b    (sl_b),
      .cin  (carry_q),
      .sum  (sl_sum),
      .cout (sl_co)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      sl_a    = a_q[4*idx_q +: 4];
      sl_b    = b_q[4*idx_q +: 4];

      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               // B is stored pre-inverted so the slice only ever adds;
               // the +1 of two's complement rides in on the carry.
               a_d     = a;
               b_d     = b ^ {W{sub}};
               carry_d = sub ? 1'b1 : cin;
               idx_d   = '0;
               sum_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            sum_d[4*idx_q +: 4] = sl_sum;
            carry_d = sl_co;
            if (idx_q == LAST) begin
               cout_d  = sl_co;
               ovf_d   = (a_q[W-1] == b_q[W-1]) && (sl_sum[3] != a_q[W-1]);
               state_d = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            if (res_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign req_ready = (state_q == IDLE);
   assign res_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;
endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
Sequencer that time-shares one 4-bit ripple adder slice (the existing fourbitadder, instantiated once inside this block) to add or subtract wide operands, one nibble per clock, LSB nibble first.
- Carry is registered between nibbles.
- Operands enter through a valid/ready request port; results leave through a valid/ready result port.
- Sits between the register file / operand muxes and the writeback path, in place of a full-width adder where area matters more than latency.

Parameters:
NIBBLES, 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES; legal range 2..16.

Ports:
clk        input   1  system clock, all logic on rising edge
rst        input   1  synchronous, active-high reset
req_valid  input   1  request holds valid operands
req_ready  output  1  block can accept a request (high only in IDLE)
a          input   W  operand A
b          input   W  operand B
cin        input   1  carry-in for add; ignored when sub=1
sub        input   1  1 = compute a - b (two's complement)
res_valid  output  1  result registers valid
res_ready  input   1  consumer takes the result
sum        output  W  result
cout       output  1  carry out of the MSB nibble; for sub, 1 = no borrow
ovf        output  1  signed overflow of the W-bit operation
busy       output  1  high in RUN or DONE

Behaviour:
- Reset is synchronous, active-high, and applies on any clk edge where rst=1, in any state. Effects:
  - state=IDLE, nibble index=0, carry register=0.
  - sum=0, cout=0, ovf=0, res_valid=0, busy=0, req_ready=1 after the edge.
  - An operation in flight is discarded; no partial result is ever presented.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid=1, latch a, and b XOR {W{sub}}; carry register <= sub ? 1 : cin; index <= 0; clear sum; go to RUN.
  - The operand sign bits needed for ovf are captured here.
- RUN:
  - req_ready=0, busy=1.
  - Each cycle the adder slice sees nibble[index] of A, nibble[index] of B', and the carry register.
  - Its sum nibble is written to sum[4*index+3 : 4*index]; carry register <= slice carry_out; index increments.
  - When index == NIBBLES-1, the write completes that cycle: cout <= slice carry_out, ovf computed, state -> DONE.
  - Index counter width is clog2(NIBBLES); it never wraps past NIBBLES-1.
- ovf = (A[W-1] == B'[W-1]) && (sum[W-1] != A[W-1]), where B' is the post-inversion operand.
- DONE:
  - res_valid=1, busy=1, req_ready=0.
  - sum/cout/ovf are held stable until the handshake res_valid && res_ready; then res_valid <= 0 and state -> IDLE.
- Latency: request accepted at edge T; res_valid is high after edge T+NIBBLES. Throughput is one operation per NIBBLES+2 cycles minimum (one IDLE bubble after each DONE).
- Simultaneous and boundary cases:
  - res_ready high in the DONE entry cycle: the handshake completes on the next edge.
  - req_valid in RUN/DONE is ignored; the requester must hold it until req_ready.
  - res_ready in IDLE/RUN has no effect.
  - Operands may change after acceptance without affecting the result.
- sum outside DONE is scratch: nibbles are partially updated during RUN and must not be sampled.

Test Plan:
- NIBBLES=4, a=0x1234, b=0x0FCD, cin=0, sub=0 -> res_valid exactly 4 cycles after accept; sum=0x2201, cout=0, ovf=0.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Also a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1 (carry ripples across all nibbles).
- sub=1, a=0x0005, b=0x0007, cin=1 (ignored) -> sum=0xFFFE, cout=0, ovf=0. Also a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, ovf=1.
- a=0x7FFF, b=0x0001, add -> sum=0x8000, cout=0, ovf=1. Hold res_ready=0 for 5 cycles -> sum/cout/ovf/res_valid stable, req_ready=0. A second req_valid with new operands is not accepted until one cycle after res_ready is taken.
- rst pulse after 2 RUN cycles of a=0xAAAA, b=0x5555 -> next cycle sum=0, res_valid=0, busy=0, req_ready=1. A subsequent request for 0x0001+0x0001 returns 0x0002 with no stale carry.
- Back-to-back: 20 random add/sub requests with req_valid held high and res_ready always 1 -> each result matches the reference model; spacing is NIBBLES+2 cycles between accepts.
